// File: rtl/hwpe_ctrl_package.sv
// Shared constants and types for the multi-context HWPE control register file.
package hwpe_ctrl_package;

    // Mandatory register word indices
    localparam int unsigned REGFILE_CXT_TRIGGER     = 0;
    localparam int unsigned REGFILE_CXT_ACQUIRE     = 1;
    localparam int unsigned REGFILE_CXT_FINISHED    = 2;
    localparam int unsigned REGFILE_CXT_STATUS      = 3;
    localparam int unsigned REGFILE_CXT_RUNNING_JOB = 4;
    localparam int unsigned REGFILE_CXT_SOFTCLR     = 5;
    localparam int unsigned REGFILE_CXT_N_MANDATORY = 8;

    // ACQUIRE responses and unmapped read pattern
    localparam logic [31:0] REGFILE_ACQUIRE_LOCKED = 32'hffff_fffe;
    localparam logic [31:0] REGFILE_ACQUIRE_FULL   = 32'hffff_ffff;
    localparam logic [31:0] REGFILE_UNMAPPED       = 32'hdead_beef;

    typedef enum logic [1:0] {
        SchedIdle,
        SchedStart,
        SchedRun
    } sched_state_e;

endpackage

// File: rtl/hwpe_ctrl_cxt_sched.sv
// In-order context scheduler: presents queued contexts to the engine, tracks the running
// pointer and job id, and counts finished jobs with a saturating, clear-on-read counter.
module hwpe_ctrl_cxt_sched
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT     = 2,
    parameter int unsigned JOB_ID_WIDTH  = 8,
    parameter int unsigned FIN_CNT_WIDTH = 2,
    parameter int unsigned CXT_W         = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_clear,
    input  logic [N_CONTEXT-1:0]     i_status,
    input  logic                     i_done,
    input  logic                     i_fin_clr,
    output logic                     o_start,
    output logic                     o_done,
    output logic                     o_idle,
    output logic [CXT_W-1:0]         o_running_cxt,
    output logic [JOB_ID_WIDTH-1:0]  o_running_job,
    output logic [FIN_CNT_WIDTH-1:0] o_finished,
    output logic                     o_evt
);

    sched_state_e               r_state;
    sched_state_e               w_state_next;
    logic [CXT_W-1:0]           r_run_ptr;
    logic [JOB_ID_WIDTH-1:0]    r_run_job;
    logic [FIN_CNT_WIDTH-1:0]   r_fin;
    logic                       r_evt;
    logic                       w_cur_busy;
    logic                       w_done;

    // Busy flag of the context at the running pointer
    always_comb begin
        w_cur_busy = 1'b0;
        for (int c = 0; c < N_CONTEXT; c++) begin
            if (CXT_W'(c) == r_run_ptr) begin
                w_cur_busy = i_status[c];
            end
        end
    end

    // Next-state and start/done decode
    always_comb begin
        w_state_next = r_state;
        o_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            SchedIdle: begin
                if (w_cur_busy) begin
                    w_state_next = SchedStart;
                end
            end
            SchedStart: begin
                o_start      = 1'b1;
                w_state_next = SchedRun;
            end
            SchedRun: begin
                // done_i outside RUN never reaches here, so it is ignored
                if (i_done) begin
                    w_done       = 1'b1;
                    w_state_next = SchedIdle;
                end
            end
            default: w_state_next = SchedIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni || i_clear) begin
            r_state <= SchedIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Running pointer, job id, finished counter and completion event
    always_ff @(posedge clk_i) begin
        if (!rst_ni || i_clear) begin
            r_run_ptr <= '0;
            r_run_job <= '0;
            r_fin     <= '0;
            r_evt     <= 1'b0;
        end else begin
            r_evt <= w_done;
            if (w_done) begin
                r_run_ptr <= (r_run_ptr == CXT_W'(N_CONTEXT - 1)) ? '0
                                                                   : r_run_ptr + CXT_W'(1);
                r_run_job <= r_run_job + JOB_ID_WIDTH'(1);
            end
            // A read clearing in the same cycle as a completion leaves exactly one pending
            if (i_fin_clr) begin
                r_fin <= w_done ? FIN_CNT_WIDTH'(1) : '0;
            end else if (w_done && (r_fin != '1)) begin
                r_fin <= r_fin + FIN_CNT_WIDTH'(1);
            end
        end
    end

    assign o_done        = w_done;
    assign o_idle        = (r_state == SchedIdle);
    assign o_running_cxt = r_run_ptr;
    assign o_running_job = r_run_job;
    assign o_finished    = r_fin;
    assign o_evt         = r_evt;

endmodule

// File: rtl/hwpe_ctrl_cxt_regfile.sv
// Multi-context HWPE control register file: per-context IO storage, offload lock,
// offload pointer and bus decode. Scheduling lives in hwpe_ctrl_cxt_sched.
module hwpe_ctrl_cxt_regfile
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT      = 2,
    parameter int unsigned N_IO_REGS      = 8,
    parameter int unsigned N_GENERIC_REGS = 0,
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned JOB_ID_WIDTH   = 8,
    parameter int unsigned FIN_CNT_WIDTH  = 2,
    parameter int unsigned ADDR_WIDTH     = 8
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic                                               req_i,
    input  logic                                               wen_i,
    input  logic [ADDR_WIDTH-1:0]                              addr_i,
    input  logic [31:0]                                        wdata_i,
    input  logic [3:0]                                         be_i,
    input  logic [ID_WIDTH-1:0]                                src_i,
    output logic [31:0]                                        rdata_o,
    output logic                                               rvalid_o,
    output logic                                               start_o,
    input  logic                                               done_i,
    output logic [((N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1)-1:0] running_cxt_o,
    output logic [N_IO_REGS*32-1:0]                            hwpe_params_o,
    output logic [((N_GENERIC_REGS > 0) ? N_GENERIC_REGS : 1)*32-1:0] generic_params_o,
    output logic                                               busy_o,
    output logic                                               evt_o
);

    localparam int unsigned CXT_W   = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int unsigned OCC_W   = $clog2(N_CONTEXT + 1);
    localparam int unsigned N_GEN_W = (N_GENERIC_REGS > 0) ? N_GENERIC_REGS : 1;
    localparam int unsigned IO_BASE = REGFILE_CXT_N_MANDATORY + N_GENERIC_REGS;
    localparam longint unsigned ADDR_SPACE = 64'd1 << ADDR_WIDTH;
    localparam longint unsigned REGS_USED  = 64'(IO_BASE + N_IO_REGS);

    if (REGS_USED > ADDR_SPACE) begin : g_bad_addr_width
        $error("hwpe_ctrl_cxt_regfile: register map does not fit in ADDR_WIDTH");
    end
    if (N_CONTEXT < 1 || N_CONTEXT > 16) begin : g_bad_n_context
        $error("hwpe_ctrl_cxt_regfile: N_CONTEXT must be 1..16");
    end
    if (JOB_ID_WIDTH < 1 || JOB_ID_WIDTH > 24) begin : g_bad_job_id_width
        $error("hwpe_ctrl_cxt_regfile: JOB_ID_WIDTH must be 1..24");
    end

    logic [31:0]              r_io [N_CONTEXT][N_IO_REGS];
    logic [31:0]              r_gen [N_GEN_W];
    logic [ID_WIDTH-1:0]      r_tag [N_CONTEXT];
    logic [N_CONTEXT-1:0]     r_status;
    logic [N_CONTEXT-1:0]     w_status_next;
    logic [OCC_W-1:0]         r_occ;
    logic [CXT_W-1:0]         r_off_ptr;
    logic [JOB_ID_WIDTH-1:0]  r_off_job;
    logic                     r_lock;
    logic [ID_WIDTH-1:0]      r_lock_src;
    logic                     r_softclr;
    logic [31:0]              r_rdata;
    logic                     r_rvalid;

    logic [31:0]              w_addr;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_clear;
    logic                     w_is_owner;
    logic                     w_locked_other;
    logic                     w_full;
    logic                     w_acq_grant;
    logic                     w_trigger;
    logic                     w_softclr_wr;
    logic                     w_fin_clr;
    logic                     w_io_wr;
    logic [31:0]              w_rdata;
    logic [31:0]              w_acq_resp;
    logic [31:0]              w_ptr_io [N_IO_REGS];
    logic                     w_sched_done;
    logic                     w_sched_idle;
    logic [CXT_W-1:0]         w_run_ptr;
    logic [JOB_ID_WIDTH-1:0]  w_run_job;
    logic [FIN_CNT_WIDTH-1:0] w_fin;
    logic                     w_unused_tags;

    assign w_addr         = 32'(addr_i);
    assign w_rd           = req_i & ~wen_i;
    assign w_wr           = req_i & wen_i;
    assign w_clear        = ~rst_ni | r_softclr;
    assign w_is_owner     = r_lock & (r_lock_src == src_i);
    assign w_locked_other = r_lock & (r_lock_src != src_i);
    assign w_full         = (r_occ == OCC_W'(N_CONTEXT));
    assign w_acq_grant    = w_rd & (w_addr == REGFILE_CXT_ACQUIRE) & ~w_locked_other & ~w_full;
    assign w_trigger      = w_wr & (w_addr == REGFILE_CXT_TRIGGER) & w_is_owner;
    assign w_softclr_wr   = w_wr & (w_addr == REGFILE_CXT_SOFTCLR);
    assign w_fin_clr      = w_rd & (w_addr == REGFILE_CXT_FINISHED);
    assign w_io_wr        = w_wr & w_is_owner;

    always_comb begin
        if (w_locked_other) begin
            w_acq_resp = REGFILE_ACQUIRE_LOCKED;
        end else if (w_full) begin
            w_acq_resp = REGFILE_ACQUIRE_FULL;
        end else begin
            w_acq_resp = 32'(r_off_job);
        end
    end

    // IO registers of the offload-pointer context, as seen by the bus
    always_comb begin
        for (int j = 0; j < N_IO_REGS; j++) begin
            w_ptr_io[j] = '0;
        end
        for (int c = 0; c < N_CONTEXT; c++) begin
            if (CXT_W'(c) == r_off_ptr) begin
                for (int j = 0; j < N_IO_REGS; j++) begin
                    w_ptr_io[j] = r_io[c][j];
                end
            end
        end
    end

    // Read data decode
    always_comb begin
        w_rdata = REGFILE_UNMAPPED;
        if (w_addr < REGFILE_CXT_N_MANDATORY) begin
            w_rdata = '0;
            case (w_addr)
                REGFILE_CXT_ACQUIRE:     w_rdata = w_acq_resp;
                REGFILE_CXT_FINISHED:    w_rdata = 32'(w_fin);
                REGFILE_CXT_STATUS:      w_rdata = 32'(r_status);
                REGFILE_CXT_RUNNING_JOB: w_rdata = 32'(w_run_job);
                default:                 w_rdata = '0;
            endcase
        end
        for (int g = 0; g < N_GENERIC_REGS; g++) begin
            if (w_addr == 32'(REGFILE_CXT_N_MANDATORY + g)) begin
                w_rdata = r_gen[g];
            end
        end
        for (int j = 0; j < N_IO_REGS; j++) begin
            if (w_addr == 32'(IO_BASE + j)) begin
                w_rdata = w_ptr_io[j];
            end
        end
    end

    // Trigger and done in the same cycle both land; done clears first, trigger sets after
    always_comb begin
        w_status_next = r_status;
        for (int c = 0; c < N_CONTEXT; c++) begin
            if (w_sched_done && (CXT_W'(c) == w_run_ptr)) begin
                w_status_next[c] = 1'b0;
            end
            if (w_trigger && (CXT_W'(c) == r_off_ptr)) begin
                w_status_next[c] = 1'b1;
            end
        end
    end

    // Soft clear is applied one cycle after the write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_softclr <= 1'b0;
        end else begin
            r_softclr <= w_softclr_wr;
        end
    end

    // Bus read response
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Lock, offload pointer, occupancy, status and per-context storage
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_lock     <= 1'b0;
            r_lock_src <= '0;
            r_off_ptr  <= '0;
            r_off_job  <= '0;
            r_occ      <= '0;
            r_status   <= '0;
            for (int c = 0; c < N_CONTEXT; c++) begin
                r_tag[c] <= '0;
                for (int j = 0; j < N_IO_REGS; j++) begin
                    r_io[c][j] <= '0;
                end
            end
        end else begin
            r_status <= w_status_next;
            if (w_trigger && !w_sched_done) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_trigger && w_sched_done) begin
                r_occ <= r_occ - OCC_W'(1);
            end
            if (w_acq_grant) begin
                r_lock     <= 1'b1;
                r_lock_src <= src_i;
            end
            for (int c = 0; c < N_CONTEXT; c++) begin
                if (CXT_W'(c) == r_off_ptr) begin
                    for (int j = 0; j < N_IO_REGS; j++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_io_wr && (w_addr == 32'(IO_BASE + j)) && be_i[b]) begin
                                r_io[c][j][8*b +: 8] <= wdata_i[8*b +: 8];
                            end
                        end
                    end
                    if (w_trigger) begin
                        r_tag[c] <= src_i + ID_WIDTH'(1);
                    end
                end
            end
            if (w_trigger) begin
                r_lock    <= 1'b0;
                r_off_ptr <= (r_off_ptr == CXT_W'(N_CONTEXT - 1)) ? '0
                                                                   : r_off_ptr + CXT_W'(1);
                r_off_job <= r_off_job + JOB_ID_WIDTH'(1);
            end
        end
    end

    if (N_GENERIC_REGS > 0) begin : g_generic
        // Shared generic registers, byte-enabled and not gated by the lock
        always_ff @(posedge clk_i) begin
            if (w_clear) begin
                for (int g = 0; g < N_GENERIC_REGS; g++) begin
                    r_gen[g] <= '0;
                end
            end else begin
                for (int g = 0; g < N_GENERIC_REGS; g++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wr && (w_addr == 32'(REGFILE_CXT_N_MANDATORY + g)) && be_i[b]) begin
                            r_gen[g][8*b +: 8] <= wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end else begin : g_no_generic
        assign r_gen[0] = '0;
    end

    // Owner tags are kept for debug visibility only
    always_comb begin
        w_unused_tags = 1'b0;
        for (int c = 0; c < N_CONTEXT; c++) begin
            w_unused_tags = w_unused_tags ^ (^r_tag[c]);
        end
    end

    // Parameter outputs: IO registers of the running context, and generic registers
    always_comb begin
        hwpe_params_o = '0;
        for (int c = 0; c < N_CONTEXT; c++) begin
            if (CXT_W'(c) == w_run_ptr) begin
                for (int j = 0; j < N_IO_REGS; j++) begin
                    hwpe_params_o[j*32 +: 32] = r_io[c][j];
                end
            end
        end
        for (int g = 0; g < N_GEN_W; g++) begin
            generic_params_o[g*32 +: 32] = r_gen[g];
        end
    end

    hwpe_ctrl_cxt_sched #(
        .N_CONTEXT    (N_CONTEXT),
        .JOB_ID_WIDTH (JOB_ID_WIDTH),
        .FIN_CNT_WIDTH(FIN_CNT_WIDTH),
        .CXT_W        (CXT_W)
    ) u_sched (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_clear      (r_softclr),
        .i_status     (r_status),
        .i_done       (done_i),
        .i_fin_clr    (w_fin_clr),
        .o_start      (start_o),
        .o_done       (w_sched_done),
        .o_idle       (w_sched_idle),
        .o_running_cxt(w_run_ptr),
        .o_running_job(w_run_job),
        .o_finished   (w_fin),
        .o_evt        (evt_o)
    );

    assign running_cxt_o = w_run_ptr;
    assign rdata_o       = r_rdata;
    assign rvalid_o      = r_rvalid;
    assign busy_o        = (r_occ != '0) | ~w_sched_idle;

endmodule

// File: tb/tb_hwpe_ctrl_cxt_regfile.sv
// Directed bench for hwpe_ctrl_cxt_regfile: a table of bus vectors followed by hand-written
// sequences for scheduling, simultaneous events, soft clear, job id wrap and reset.
module tb_hwpe_ctrl_cxt_regfile;

    localparam int unsigned NC  = 2;
    localparam int unsigned NIO = 8;
    localparam int unsigned NG  = 1;
    localparam int unsigned IDW = 16;
    localparam int unsigned JW  = 2;
    localparam int unsigned FW  = 2;
    localparam int unsigned AW  = 8;

    localparam logic [7:0] A_TRIG = 8'd0;
    localparam logic [7:0] A_ACQ  = 8'd1;
    localparam logic [7:0] A_FIN  = 8'd2;
    localparam logic [7:0] A_STAT = 8'd3;
    localparam logic [7:0] A_RJOB = 8'd4;
    localparam logic [7:0] A_SCLR = 8'd5;
    localparam logic [7:0] A_GEN0 = 8'd8;
    localparam logic [7:0] A_IO0  = 8'd9;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              wen_i = 1'b0;
    logic [AW-1:0]     addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic [3:0]        be_i = '0;
    logic [IDW-1:0]    src_i = '0;
    logic [31:0]       rdata_o;
    logic              rvalid_o;
    logic              start_o;
    logic              done_i = 1'b0;
    logic [0:0]        running_cxt_o;
    logic [NIO*32-1:0] hwpe_params_o;
    logic [31:0]       generic_params_o;
    logic              busy_o;
    logic              evt_o;

    always #5 clk = ~clk;

    hwpe_ctrl_cxt_regfile #(
        .N_CONTEXT     (NC),
        .N_IO_REGS     (NIO),
        .N_GENERIC_REGS(NG),
        .ID_WIDTH      (IDW),
        .JOB_ID_WIDTH  (JW),
        .FIN_CNT_WIDTH (FW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .wen_i           (wen_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .be_i            (be_i),
        .src_i           (src_i),
        .rdata_o         (rdata_o),
        .rvalid_o        (rvalid_o),
        .start_o         (start_o),
        .done_i          (done_i),
        .running_cxt_o   (running_cxt_o),
        .hwpe_params_o   (hwpe_params_o),
        .generic_params_o(generic_params_o),
        .busy_o          (busy_o),
        .evt_o           (evt_o)
    );

    typedef struct {
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [15:0] src;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int evt_cnt = 0;
    int exp_starts = 0;

    always @(posedge clk) begin
        if (start_o) start_cnt++;
        if (evt_o) evt_cnt++;
    end

    function automatic vec_t mk(input logic wen, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [15:0] src,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.be = be; v.src = src;
        v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic [15:0] src);
        @(negedge clk);
        req_i = 1'b1; wen_i = 1'b1; addr_i = addr; wdata_i = data; be_i = be; src_i = src;
        @(negedge clk);
        req_i = 1'b0; wen_i = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] addr, input logic [15:0] src,
                              input logic [31:0] exp);
        @(negedge clk);
        req_i = 1'b1; wen_i = 1'b0; addr_i = addr; src_i = src;
        @(negedge clk);
        req_i = 1'b0;
        check({name, " rvalid"}, 32'(rvalid_o), 32'd1);
        check(name, rdata_o, exp);
    endtask

    task automatic do_done();
        @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
    endtask

    task automatic wait_starts();
        int n = 0;
        while (start_cnt < exp_starts && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start pulse count", 32'(start_cnt), 32'(exp_starts));
    endtask

    initial begin
        // Phase 1: table of bus vectors from reset
        tbl.push_back(mk(0, A_ACQ,  0, 4'hf, 3, 32'h0000_0000, "acquire src3 after reset"));
        tbl.push_back(mk(0, A_STAT, 0, 4'hf, 3, 32'h0000_0000, "status after reset"));
        tbl.push_back(mk(0, 8'd6,   0, 4'hf, 3, 32'h0000_0000, "reserved addr 6"));
        tbl.push_back(mk(0, A_ACQ,  0, 4'hf, 3, 32'h0000_0000, "owner re-acquire"));
        tbl.push_back(mk(1, A_IO0,  32'h1234, 4'hf, 3, 0, "io0 write cxt0"));
        tbl.push_back(mk(0, A_ACQ,  0, 4'hf, 5, 32'hffff_fffe, "acquire locked by other"));
        tbl.push_back(mk(1, A_IO0,  32'hdead, 4'hf, 5, 0, "io write non-owner"));
        tbl.push_back(mk(1, A_TRIG, 0, 4'hf, 5, 0, "trigger non-owner"));
        tbl.push_back(mk(0, A_STAT, 0, 4'hf, 3, 32'h0000_0000, "status after bad trigger"));
        tbl.push_back(mk(1, A_TRIG, 0, 4'hf, 3, 0, "trigger cxt0"));
        tbl.push_back(mk(0, A_ACQ,  0, 4'hf, 3, 32'h0000_0001, "acquire second cxt"));
        tbl.push_back(mk(1, A_IO0,  32'h5678, 4'hf, 3, 0, "io0 write cxt1"));
        tbl.push_back(mk(1, A_TRIG, 0, 4'hf, 3, 0, "trigger cxt1"));
        tbl.push_back(mk(0, A_STAT, 0, 4'hf, 3, 32'h0000_0003, "status both busy"));
        tbl.push_back(mk(0, A_ACQ,  0, 4'hf, 7, 32'hffff_ffff, "acquire when full"));
        tbl.push_back(mk(0, A_RJOB, 0, 4'hf, 3, 32'h0000_0000, "running job first"));
        tbl.push_back(mk(0, 8'd200, 0, 4'hf, 3, 32'hdead_beef, "unmapped addr"));
        tbl.push_back(mk(0, A_FIN,  0, 4'hf, 3, 32'h0000_0000, "finished before done"));
        tbl.push_back(mk(1, A_GEN0, 32'haabb_ccdd, 4'b0101, 5, 0, "generic write be"));
        tbl.push_back(mk(0, A_GEN0, 0, 4'hf, 5, 32'h00bb_00dd, "generic read be"));
        tbl.push_back(mk(0, A_IO0,  0, 4'hf, 9, 32'h0000_1234, "io0 read at pointer cxt0"));

        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset start_o", 32'(start_o), 32'd0);
        check("reset rvalid_o", 32'(rvalid_o), 32'd0);
        check("reset hwpe_params", hwpe_params_o[31:0], 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wen) begin
                bus_write(tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].src);
            end else begin
                read_check(tbl[i].name, tbl[i].addr, tbl[i].src, tbl[i].exp);
            end
        end
        exp_starts = 1;
        check("single start pulse", 32'(start_cnt), 32'd1);
        check("hwpe_params cxt0 io0", hwpe_params_o[31:0], 32'h0000_1234);
        check("running cxt 0", 32'(running_cxt_o), 32'd0);
        check("busy while running", 32'(busy_o), 32'd1);
        check("generic_params", generic_params_o, 32'h00bb_00dd);

        // Phase 2: complete cxt0, then trigger and done in the same cycle
        do_done();
        exp_starts = 2;
        wait_starts();
        check("running cxt 1", 32'(running_cxt_o), 32'd1);
        check("hwpe_params cxt1 io0", hwpe_params_o[31:0], 32'h0000_5678);
        read_check("status cxt1 only", A_STAT, 3, 32'd2);
        read_check("acquire job 2", A_ACQ, 3, 32'd2);
        bus_write(A_IO0, 32'h9abc, 4'hf, 3);
        @(negedge clk);
        req_i = 1'b1; wen_i = 1'b1; addr_i = A_TRIG; src_i = 3; done_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0; wen_i = 1'b0; done_i = 1'b0;
        read_check("status after trig+done", A_STAT, 3, 32'd1);
        read_check("acquire job 3 not full", A_ACQ, 3, 32'd3);
        read_check("running job 2", A_RJOB, 3, 32'd2);
        exp_starts = 3;
        wait_starts();
        check("hwpe_params cxt0 reused", hwpe_params_o[31:0], 32'h0000_9abc);
        do_done();
        read_check("finished 3", A_FIN, 3, 32'd3);
        read_check("finished cleared", A_FIN, 3, 32'd0);
        check("evt count 3", 32'(evt_cnt), 32'd3);

        // Phase 3: soft clear while a context runs
        bus_write(A_TRIG, 0, 4'hf, 3);
        exp_starts = 4;
        wait_starts();
        check("busy before softclr", 32'(busy_o), 32'd1);
        bus_write(A_SCLR, 32'h1, 4'hf, 9);
        @(negedge clk);
        check("softclr busy_o", 32'(busy_o), 32'd0);
        check("softclr start_o", 32'(start_o), 32'd0);
        check("softclr running cxt", 32'(running_cxt_o), 32'd0);
        check("softclr hwpe_params", hwpe_params_o[31:0], 32'd0);
        check("softclr generic", generic_params_o, 32'd0);
        read_check("softclr status", A_STAT, 3, 32'd0);
        read_check("softclr running job", A_RJOB, 3, 32'd0);
        read_check("softclr acquire", A_ACQ, 3, 32'd0);

        // Phase 4: five full offloads, job id wraps at 2^JW; finished saturates
        for (int k = 0; k < 5; k++) begin
            read_check($sformatf("wrap acquire %0d", k), A_ACQ, 3, 32'(k % 4));
            bus_write(A_TRIG, 0, 4'hf, 3);
            exp_starts++;
            wait_starts();
            do_done();
        end
        read_check("finished saturated", A_FIN, 3, 32'd3);
        read_check("running job wrapped", A_RJOB, 3, 32'd1);
        check("evt count 8", 32'(evt_cnt), 32'd8);

        // Phase 5: FINISHED read coinciding with a done
        read_check("acquire job 1", A_ACQ, 3, 32'd1);
        bus_write(A_TRIG, 0, 4'hf, 3);
        exp_starts++;
        wait_starts();
        do_done();
        read_check("acquire job 2b", A_ACQ, 3, 32'd2);
        bus_write(A_TRIG, 0, 4'hf, 3);
        exp_starts++;
        wait_starts();
        @(negedge clk);
        req_i = 1'b1; wen_i = 1'b0; addr_i = A_FIN; src_i = 3; done_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0; done_i = 1'b0;
        check("fin read with done old value", rdata_o, 32'd1);
        read_check("fin after read+done", A_FIN, 3, 32'd1);

        // Phase 6: hard reset for one clock in RUN
        read_check("acquire job 3b", A_ACQ, 3, 32'd3);
        bus_write(A_TRIG, 0, 4'hf, 3);
        exp_starts++;
        wait_starts();
        check("busy before reset", 32'(busy_o), 32'd1);
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check("mid-run reset start_o", 32'(start_o), 32'd0);
        check("mid-run reset busy_o", 32'(busy_o), 32'd0);
        read_check("mid-run reset status", A_STAT, 3, 32'd0);
        read_check("mid-run reset acquire", A_ACQ, 3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_cxt_regfile.md
Name: hwpe_ctrl_cxt_regfile

Overview:
- Parametrised multi-context control register file for HWPE slave ports. Replaces the fixed 4-context, 8-bit-job-id regfile.
- Stores per-context IO registers in flip-flops and handles the acquire/trigger offload protocol. Schedules queued contexts to the engine in order.
- Adds a saturating finished counter of configurable width, an offload lock keyed to the acquiring source, a soft-clear register, and simultaneous trigger/done handling.

Parameters:
- N_CONTEXT, 2: number of contexts, 1..16.
- N_IO_REGS, 8: per-context IO registers.
- N_GENERIC_REGS, 0: shared, non-contexted registers.
- ID_WIDTH, 16: width of the source id.
- JOB_ID_WIDTH, 8: width of the job id counters, 1..24.
- FIN_CNT_WIDTH, 2: width of the finished counter; it saturates at 2^FIN_CNT_WIDTH-1.
- ADDR_WIDTH, 8: word address width. Elaboration assertion: 8+N_GENERIC_REGS+N_IO_REGS <= 2^ADDR_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous and active-low.
- req_i  in  1  bus request. Always granted.
- wen_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables.
- src_i  in  ID_WIDTH  requester id.
- rdata_o  out  32  read data.
- rvalid_o  out  1  read data valid.
- start_o  out  1  engine start pulse.
- done_i  in  1  engine done pulse.
- running_cxt_o  out  max(1,$clog2(N_CONTEXT))  context currently presented to the engine.
- hwpe_params_o  out  N_IO_REGS*32  IO registers of the running context.
- generic_params_o  out  max(1,N_GENERIC_REGS)*32  generic registers. Tied to 0 when N_GENERIC_REGS=0.
- busy_o  out  1  at least one context queued or running.
- evt_o  out  1  one-cycle pulse per completed job.

Behaviour:
- Reset: all storage, counters, pointers and outputs go to 0 on the clock edge when rst_ni=0. Soft clear has the same effect one cycle after the write.
- Read latency is 1 cycle: rvalid_o=1 the cycle after req_i&~wen_i, with rdata_o valid in that cycle. rdata_o holds its value otherwise.
- Register map, by word index:
  - 0 TRIGGER (W)
  - 1 ACQUIRE (R)
  - 2 FINISHED (R, clear-on-read)
  - 3 STATUS (R): bit i = context i busy
  - 4 RUNNING_JOB (R)
  - 5 SOFT_CLEAR (W)
  - 6 and 7 reserved: read 0, writes ignored
  - 8..8+N_GENERIC_REGS-1: generic registers
  - following N_IO_REGS words: IO registers of the pointer context
  - unmapped addresses read 32'hdeadbeef
- be_i applies only to generic and IO writes. Mandatory registers ignore be_i.
- Offload lock:
  - ACQUIRE with the lock held by a different src returns 32'hfffffffe.
  - Else, if occupancy==N_CONTEXT, it returns 32'hffffffff.
  - Else it returns the zero-extended offload_job_id, sets the lock and records src_i.
  - Re-acquire by the lock owner returns the same id, with no side effects.
- IO writes go to the pointer context while the lock is held by src_i. Otherwise they are dropped.
- TRIGGER from the lock owner:
  - marks the pointer context busy
  - advances the pointer modulo N_CONTEXT and increments offload_job_id
  - releases the lock and records src_i+1 as the context's owner tag (internal)
- TRIGGER without owning the lock is ignored.
- Scheduler FSM:
  - IDLE -> START when the context at the running pointer is busy.
  - START drives start_o=1 for one cycle -> RUN.
  - In RUN, done_i=1: clear that context's busy bit, advance the running pointer, increment running_job_id, saturating-increment FINISHED, pulse evt_o next cycle, go to IDLE.
  - done_i outside RUN is ignored.
- Occupancy = popcount(STATUS), maintained as a counter.
- Trigger and done in the same cycle: both take effect and occupancy is unchanged. An ACQUIRE in that cycle sees the pre-update occupancy.
- A FINISHED read in the same cycle as a done increment: the read returns the old value and the counter becomes 1.
- Job id counters wrap modulo 2^JOB_ID_WIDTH.
- N_CONTEXT=1: pointers are constant 0 and full equals busy.
- busy_o = (occupancy!=0) | (state!=IDLE).

Decomposition:
- hwpe_ctrl_package holds:
  - register index constants: REGFILE_CXT_TRIGGER..REGFILE_CXT_SOFTCLR, REGFILE_CXT_N_MANDATORY=8
  - ACQUIRE response constants
  - the scheduler state enum
- One sub-module: hwpe_ctrl_cxt_sched, containing the FSM, running pointer, running_job_id, FINISHED and evt generation.
- The top module keeps storage, the lock, the offload pointer and bus decode.

Test Plan:
- Reset then read ACQUIRE from src 3 -> 0x00000000. Read STATUS -> 0. Read addr 6 -> 0.
- N_CONTEXT=2: src 3 acquires, writes IO0=0x1234, triggers; repeat -> STATUS=0b11. Next ACQUIRE -> 0xffffffff. start_o pulses once; hwpe_params_o[31:0]=0x1234.
- src 3 acquires, then src 5 acquires -> 0xfffffffe; src 5 IO write dropped; src 5 TRIGGER ignored, STATUS unchanged.
- Three done_i with FIN_CNT_WIDTH=2 and no reads -> FINISHED=3 after the third done. First read returns 3, second read returns 0. evt_o pulsed 3 times.
- TRIGGER and done_i in the same cycle with one context running -> occupancy stays 1; running_job_id +1; offload_job_id +1.
- JOB_ID_WIDTH=2: five complete offloads -> ACQUIRE returns 0,1,2,3,0. SOFT_CLEAR write -> all state is 0 the next cycle. Asserting rst_ni=0 for one clock mid-RUN -> start_o, busy_o and STATUS are 0 after that edge.
